// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: realises 0..63-bit logical-left / arithmetic-right
// shifts by chaining 8-bit and 1-bit steps of a four-op shift datapath.
module shift_sequencer #(
    parameter int WIDTH    = 64,
    parameter int BIG_STEP = 8,
    parameter int DIST_W   = 6
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic              cmd_dir,
    input  logic [DIST_W-1:0] cmd_dist,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  q,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [DIST_W-1:0] BIG = DIST_W'(BIG_STEP);
    localparam logic [DIST_W-1:0] ONE = DIST_W'(1);

    state_t            state;
    state_t            state_next;
    logic [DIST_W-1:0] rem;
    logic [DIST_W-1:0] rem_next;
    logic [DIST_W-1:0] rem_stepped;
    logic              dir;
    logic              dir_next;
    logic [WIDTH-1:0]  q_next;
    logic [WIDTH-1:0]  shifted;
    logic              big_op;

    // Large steps are taken first so the step count is dist/8 + dist%8.
    assign big_op      = (rem >= BIG);
    assign rem_stepped = big_op ? (rem - BIG) : (rem - ONE);

    always_comb begin
        shifted = q;
        case ({dir, big_op})
            2'b00:   shifted = {q[WIDTH-2:0], 1'b0};
            2'b01:   shifted = {q[WIDTH-BIG_STEP-1:0], {BIG_STEP{1'b0}}};
            2'b10:   shifted = {q[WIDTH-1], q[WIDTH-1:1]};
            default: shifted = {{BIG_STEP{q[WIDTH-1]}}, q[WIDTH-1:BIG_STEP]};
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            q   <= '0;
            rem <= '0;
            dir <= 1'b0;
        end else begin
            q   <= q_next;
            rem <= rem_next;
            dir <= dir_next;
        end
    end

    always_comb begin
        state_next = state;
        q_next     = q;
        rem_next   = rem;
        dir_next   = dir;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    q_next     = cmd_data;
                    rem_next   = cmd_dist;
                    dir_next   = cmd_dir;
                    state_next = (cmd_dist == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                q_next   = shifted;
                rem_next = rem_stepped;
                if (rem_stepped == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases, back-pressure, async reset, then
// randomized traffic compared cycle by cycle against a countdown/result model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_data;
    logic        cmd_dir;
    logic [5:0]  cmd_dist;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] q;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    shift_sequencer dut (
        .clk       (clk),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_dist  (cmd_dist),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .q         (q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_shift(input logic [63:0] d, input logic r, input logic [5:0] n);
        if (r) return 64'($signed(d) >>> n);
        return d << n;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 counting down steps, 2 result presented.
    int          m_phase   = 0;
    int          m_cnt     = 0;
    int          m_accepts = 0;
    logic [63:0] m_result  = '0;
    logic [63:0] m_q_idle  = '0;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            m_phase  = 0;
            m_cnt    = 0;
            m_result = '0;
            m_q_idle = '0;
        end else begin
            case (m_phase)
                0: if (cmd_valid) begin
                    m_result = model_shift(cmd_data, cmd_dir, cmd_dist);
                    m_cnt    = int'(cmd_dist) / 8 + int'(cmd_dist) % 8;
                    m_phase  = (m_cnt == 0) ? 2 : 1;
                    m_accepts++;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: if (res_ready) begin
                    m_phase  = 0;
                    m_q_idle = m_result;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (areset === 1'b0) begin
            check_output("cmp_cmd_ready", {63'b0, cmd_ready}, {63'b0, m_phase == 0});
            check_output("cmp_res_valid", {63'b0, res_valid}, {63'b0, m_phase == 2});
            check_output("cmp_busy", {63'b0, busy}, {63'b0, m_phase != 0});
            if (m_phase == 2) check_output("cmp_q_result", q, m_result);
            if (m_phase == 0) check_output("cmp_q_idle", q, m_q_idle);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [63:0] d, input logic r, input logic [5:0] n);
        int guard = 0;
        while (!cmd_ready && guard < 100) begin
            step();
            guard++;
        end
        if (!cmd_ready) begin
            failures++;
            $display("[TB] FAIL accept_timeout: cmd_ready stayed %b, required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = r;
        cmd_dist  = n;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 100) begin
            step();
            cycles++;
        end
        if (!res_valid) begin
            failures++;
            $display("[TB] FAIL result_timeout: res_valid stayed %b, required 1", res_valid);
        end
    endtask

    task automatic drain();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check_output("drain_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    endtask

    task automatic run_directed(input string name, input logic [63:0] d, input logic r,
                                input logic [5:0] n, input logic [63:0] exp_q, input int exp_steps);
        int cycles;
        apply_stimulus(d, r, n);
        wait_result(cycles);
        check_output({name, "_latency"}, 64'(cycles), 64'(exp_steps));
        check_output({name, "_q"}, q, exp_q);
        drain();
    endtask

    logic [63:0] held;
    int          cycles;
    int          budget;

    initial begin
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_dist  = '0;
        res_ready = 1'b0;
        #12;
        check_output("reset_q", q, 64'd0);
        check_output("reset_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        check_output("reset_res_valid", {63'b0, res_valid}, 64'd0);
        check_output("reset_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        #2 areset = 1'b0;
        step();

        check_output("model_left9", model_shift(64'h100, 1'b0, 6'd9), 64'h20000);
        check_output("model_r63", model_shift(64'h8000_0000_0000_0000, 1'b1, 6'd63), 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("model_r12", model_shift(64'h4000_0000_0000_0000, 1'b1, 6'd12), 64'h0004_0000_0000_0000);

        run_directed("zero", 64'h100, 1'b0, 6'd0, 64'h100, 0);
        run_directed("left9", 64'h100, 1'b0, 6'd9, 64'h20000, 2);
        run_directed("right63", 64'h8000_0000_0000_0000, 1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 14);
        run_directed("right12", 64'h4000_0000_0000_0000, 1'b1, 6'd12, 64'h0004_0000_0000_0000, 5);
        run_directed("left63", 64'h3, 1'b0, 6'd63, 64'h8000_0000_0000_0000, 14);

        // Back-pressure: result must hold while commands are offered.
        apply_stimulus(64'h0000_0000_0000_00F1, 1'b0, 6'd3);
        wait_result(cycles);
        held = q;
        check_output("bp_q", held, 64'h788);
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = {$urandom, $urandom};
            cmd_dist  = 6'd5;
            step();
            check_output("bp_hold_q", q, held);
            check_output("bp_hold_valid", {63'b0, res_valid}, 64'd1);
            check_output("bp_hold_ready", {63'b0, cmd_ready}, 64'd0);
        end
        res_ready = 1'b1;
        cmd_data  = 64'h1234;
        cmd_dir   = 1'b0;
        cmd_dist  = 6'd4;
        step();
        res_ready = 1'b0;
        check_output("bp_release_ready", {63'b0, cmd_ready}, 64'd1);
        check_output("bp_release_q", q, held);
        step();
        cmd_valid = 1'b0;
        check_output("bp_accept_busy", {63'b0, busy}, 64'd1);
        check_output("bp_accept_q", q, 64'h1234);
        wait_result(cycles);
        check_output("bp_new_result", q, 64'h12340);
        drain();

        // Asynchronous reset in the middle of a long shift.
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd40);
        step();
        step();
        #2 areset = 1'b1;
        #1;
        check_output("arst_q", q, 64'd0);
        check_output("arst_res_valid", {63'b0, res_valid}, 64'd0);
        check_output("arst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        check_output("arst_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        #2 areset = 1'b0;
        step();
        run_directed("after_reset", 64'h1, 1'b0, 6'd40, 64'h0000_0100_0000_0000, 5);

        // Random traffic; fields change every cycle, including while busy.
        m_accepts = 0;
        budget    = 0;
        while (m_accepts < 2000 && budget < 60000) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_data  = {$urandom, $urandom};
            cmd_dir   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       cmd_dist = 6'd0;
                1:       cmd_dist = 6'd63;
                2:       cmd_dist = 6'd8;
                default: cmd_dist = 6'($urandom_range(0, 63));
            endcase
            res_ready = 1'($urandom_range(0, 1));
            step();
            budget++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        check_output("random_accepts", 64'(m_accepts), 64'd2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
